// File: rtl/pwm_carrier_gen.sv
// -----------------------------------------------------------------------------
// pwm_carrier_gen_pkg / pwm_carrier_gen
//
// Carrier counter for one PWM channel. Generates the carrier value and its
// direction, single-cycle min/max event pulses, and a registered maskevent
// pulse that clocks the downstream event counter. The period is double
// buffered (period_sh reloads only where the carrier wraps/turns at 0) and the
// tick rate is divided by a prescaler.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   pwm_onoff  in   channel enable (PWM_OFF = stopped)
//   countmode  in   NO_COUNT / UP_COUNT / DOWN_COUNT / UPDOWN_COUNT
//   period_in  in   requested carrier period P
//   presc      in   tick every presc+1 clk cycles
//   evt_sel    in   maskevent source: 00 none, 01 min, 10 max, 11 min|max
//   carrier    out  carrier value
//   dir_down   out  1 while counting down
//   evt_min    out  1-clk pulse when the updated carrier is 0
//   evt_max    out  1-clk pulse when the updated carrier equals period_sh
//   maskevent  out  registered OR of the selected events
// -----------------------------------------------------------------------------
package pwm_carrier_gen_pkg;

  typedef enum logic [1:0] {
    NO_COUNT     = 2'd0,
    UP_COUNT     = 2'd1,
    DOWN_COUNT   = 2'd2,
    UPDOWN_COUNT = 2'd3
  } count_mode_t;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } pwm_onoff_t;

endpackage

module pwm_carrier_gen
  import pwm_carrier_gen_pkg::*;
#(
  parameter int unsigned CARR_WIDTH  = 16,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  pwm_onoff_t             pwm_onoff,
  input  count_mode_t            countmode,
  input  logic [CARR_WIDTH-1:0]  period_in,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic [1:0]             evt_sel,
  output logic [CARR_WIDTH-1:0]  carrier,
  output logic                   dir_down,
  output logic                   evt_min,
  output logic                   evt_max,
  output logic                   maskevent
);

  logic [CARR_WIDTH-1:0]  period_sh;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  // High from the second clk of a run onward; the first clk only preloads.
  logic                   primed;

  logic                   run_c;
  logic                   tick_c;
  logic [CARR_WIDTH-1:0]  carrier_nxt_c;
  logic                   dir_nxt_c;
  logic                   load_c;
  logic                   going_down_c;
  logic [CARR_WIDTH-1:0]  period_new_c;
  logic [CARR_WIDTH-1:0]  start_c;
  logic                   mask_c;

  assign run_c   = (pwm_onoff == PWM_ON) && (countmode != NO_COUNT);
  assign tick_c  = run_c && primed && (presc_cnt == presc);
  assign start_c = (countmode == DOWN_COUNT) ? period_in : '0;
  assign mask_c  = run_c && ((evt_sel[0] && evt_min) || (evt_sel[1] && evt_max));

  // Next carrier/direction for a tick, plus whether the shadow period reloads.
  always_comb begin
    carrier_nxt_c = carrier;
    dir_nxt_c     = dir_down;
    load_c        = 1'b0;
    going_down_c  = 1'b0;
    case (countmode)
      UP_COUNT: begin
        dir_nxt_c = 1'b0;
        if (carrier >= period_sh) begin
          carrier_nxt_c = '0;
          load_c        = 1'b1;
        end else begin
          carrier_nxt_c = carrier + CARR_WIDTH'(1);
        end
      end
      DOWN_COUNT: begin
        dir_nxt_c = 1'b1;
        if (carrier == '0) begin
          // Reload uses the incoming period so the new cycle starts at its top.
          carrier_nxt_c = period_in;
          load_c        = 1'b1;
        end else begin
          carrier_nxt_c = carrier - CARR_WIDTH'(1);
        end
      end
      UPDOWN_COUNT: begin
        if (dir_down && (carrier != '0)) begin
          carrier_nxt_c = carrier - CARR_WIDTH'(1);
          going_down_c  = 1'b1;
        end else if (!dir_down && (carrier < period_sh)) begin
          carrier_nxt_c = carrier + CARR_WIDTH'(1);
        end else if (carrier != '0) begin
          // Up-counting but already at the top (e.g. after a mode switch): turn.
          carrier_nxt_c = carrier - CARR_WIDTH'(1);
          going_down_c  = 1'b1;
        end else begin
          carrier_nxt_c = '0;
        end
        if (carrier_nxt_c == '0) begin
          load_c    = 1'b1;
          dir_nxt_c = 1'b0;
        end else if (going_down_c) begin
          dir_nxt_c = 1'b1;
        end else begin
          dir_nxt_c = (carrier_nxt_c == period_sh);
        end
      end
      NO_COUNT: begin
        carrier_nxt_c = carrier;
      end
    endcase
    period_new_c = load_c ? period_in : period_sh;
  end

  // Carrier, shadow period, prescaler and event registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carrier   <= '0;
      dir_down  <= 1'b0;
      evt_min   <= 1'b0;
      evt_max   <= 1'b0;
      maskevent <= 1'b0;
      period_sh <= '0;
      presc_cnt <= '0;
      primed    <= 1'b0;
    end else begin
      primed    <= run_c;
      maskevent <= mask_c;
      if (!run_c || !primed) begin
        period_sh <= period_in;
        carrier   <= start_c;
        dir_down  <= (countmode == DOWN_COUNT);
        presc_cnt <= '0;
        evt_min   <= 1'b0;
        evt_max   <= 1'b0;
      end else begin
        // A count above a freshly lowered presc wraps without a tick.
        presc_cnt <= (presc_cnt >= presc) ? '0 : presc_cnt + PRESC_WIDTH'(1);
        if (tick_c) begin
          carrier   <= carrier_nxt_c;
          dir_down  <= dir_nxt_c;
          period_sh <= period_new_c;
          evt_min   <= (carrier_nxt_c == '0);
          evt_max   <= (carrier_nxt_c == period_new_c);
        end else begin
          evt_min   <= 1'b0;
          evt_max   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Self-checking bench for pwm_carrier_gen: directed scenarios plus a random
// phase, all compared every clk against a cycle-level reference model.
module tb_pwm_carrier_gen;
  import pwm_carrier_gen_pkg::*;

  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  pwm_onoff_t    onoff;
  count_mode_t   mode;
  logic [CW-1:0] pin;
  logic [PW-1:0] presc;
  logic [1:0]    sel;
  logic [CW-1:0] carrier;
  logic          dir_down, evt_min, evt_max, maskevent;

  pwm_carrier_gen #(.CARR_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .pwm_onoff(onoff), .countmode(mode),
    .period_in(pin), .presc(presc), .evt_sel(sel),
    .carrier(carrier), .dir_down(dir_down), .evt_min(evt_min),
    .evt_max(evt_max), .maskevent(maskevent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int m_car, m_psh, m_cnt;
  bit m_dir, m_primed, m_emin, m_emax, m_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_car = 0; m_psh = 0; m_cnt = 0;
    m_dir = 0; m_primed = 0; m_emin = 0; m_emax = 0; m_mask = 0;
  endtask

  // One clk of the channel, from the inputs as seen at this edge.
  task automatic model_step();
    bit run, tick;
    int p2, ph;
    run    = (onoff == PWM_ON) && (mode != NO_COUNT);
    m_mask = run && ((sel[0] && m_emin) || (sel[1] && m_emax));
    if (!run || !m_primed) begin
      m_psh    = int'(pin);
      m_car    = (mode == DOWN_COUNT) ? int'(pin) : 0;
      m_dir    = (mode == DOWN_COUNT);
      m_cnt    = 0;
      m_emin   = 0;
      m_emax   = 0;
      m_primed = run;
      return;
    end
    tick  = (m_cnt == int'(presc));
    m_cnt = (m_cnt >= int'(presc)) ? 0 : m_cnt + 1;
    if (!tick) begin
      m_emin = 0;
      m_emax = 0;
      return;
    end
    if (mode == UP_COUNT) begin
      m_dir = 0;
      if (m_car == m_psh) begin m_car = 0; m_psh = int'(pin); end
      else m_car = m_car + 1;
    end else if (mode == DOWN_COUNT) begin
      m_dir = 1;
      if (m_car == 0) begin m_psh = int'(pin); m_car = m_psh; end
      else m_car = m_car - 1;
    end else begin
      // Up/down as a position within a 2P-tick cycle.
      if (m_psh == 0) begin
        m_car = 0; m_dir = 0; m_psh = int'(pin);
      end else begin
        p2 = 2 * m_psh;
        ph = (m_dir ? p2 - m_car : m_car) + 1;
        if (ph >= p2) begin
          m_car = 0; m_dir = 0; m_psh = int'(pin);
        end else begin
          m_car = (ph <= m_psh) ? ph : p2 - ph;
          m_dir = (ph >= m_psh);
        end
      end
    end
    m_emin = (m_car == 0);
    m_emax = (m_car == m_psh);
  endtask

  task automatic check_all();
    check("carrier",   32'(carrier),   32'(m_car));
    check("dir_down",  32'(dir_down),  32'(m_dir));
    check("evt_min",   32'(evt_min),   32'(m_emin));
    check("evt_max",   32'(evt_max),   32'(m_emax));
    check("maskevent", 32'(maskevent), 32'(m_mask));
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_all();
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    cyc++;
    #1;
    check_all();
    reset = 1'b0;
  endtask

  task automatic stop_channel();
    onoff = PWM_OFF;
    cycle();
  endtask

  int exp_ud_car [13] = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0};
  int exp_ud_dir [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
  int exp_dn_car [9]  = '{4, 3, 2, 1, 0, 2, 1, 0, 2};

  initial begin
    int n_max, n_min;
    reset = 1'b1; onoff = PWM_OFF; mode = NO_COUNT;
    pin = '0; presc = '0; sel = 2'b00;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    cycle();

    // UP, P=4, presc=0, maskevent on min
    mode = UP_COUNT; pin = 16'd4; presc = '0; sel = 2'b01; onoff = PWM_ON;
    cycle();
    check("up_prime_car", 32'(carrier), 32'd0);
    check("up_prime_evt", 32'({evt_min, evt_max}), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check("up_seq", 32'(carrier), 32'(i));
    end
    check("up_evt_max", 32'(evt_max), 32'd1);
    cycle();
    check("up_wrap", 32'(carrier), 32'd0);
    check("up_evt_min", 32'(evt_min), 32'd1);
    cycle();
    check("up_mask", 32'(maskevent), 32'd1);
    cycle();
    check("up_mask_1clk", 32'(maskevent), 32'd0);
    stop_channel();

    // UPDOWN, P=3, presc=1
    mode = UPDOWN_COUNT; pin = 16'd3; presc = 8'd1; sel = 2'b11; onoff = PWM_ON;
    n_max = 0; n_min = 0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      check("ud_car", 32'(carrier), 32'(exp_ud_car[i]));
      check("ud_dir", 32'(dir_down), 32'(exp_ud_dir[i]));
      n_max += int'(evt_max);
      n_min += int'(evt_min);
    end
    check("ud_nmax", 32'(n_max), 32'd1);
    check("ud_nmin", 32'(n_min), 32'd1);
    cycle();
    check("ud_min_1clk", 32'(evt_min), 32'd0);
    stop_channel();

    // DOWN, P=5, period changed to 2 mid-cycle
    mode = DOWN_COUNT; pin = 16'd5; presc = '0; sel = 2'b10; onoff = PWM_ON;
    cycle();
    check("dn_prime", 32'(carrier), 32'd5);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("dn_seq", 32'(carrier), 32'(exp_dn_car[i]));
      if (i == 1) pin = 16'd2;
    end
    stop_channel();

    // Reset while UP carrier=3, then restart with run held high
    mode = UP_COUNT; pin = 16'd6; sel = 2'b01; onoff = PWM_ON;
    repeat (4) cycle();
    check("rst_pre", 32'(carrier), 32'd3);
    do_reset();
    check("rst_car", 32'(carrier), 32'd0);
    cycle();
    check("rst_restart_car", 32'(carrier), 32'd0);
    check("rst_no_evt", 32'({evt_min, evt_max}), 32'd0);
    cycle();
    check("rst_count", 32'(carrier), 32'd1);
    stop_channel();

    // P=0: both events every tick; maskevent drops the clk after run falls
    mode = UP_COUNT; pin = 16'd0; sel = 2'b11; onoff = PWM_ON;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("p0_evts", 32'({evt_min, evt_max}), 32'd3);
      check("p0_car", 32'(carrier), 32'd0);
    end
    check("p0_mask", 32'(maskevent), 32'd1);
    onoff = PWM_OFF;
    cycle();
    check("off_mask", 32'(maskevent), 32'd0);

    // evt_sel=11, UP P=2: maskevent after every selected event
    mode = UP_COUNT; pin = 16'd2; presc = '0; sel = 2'b11; onoff = PWM_ON;
    repeat (12) cycle();
    stop_channel();

    // Random phase
    onoff = PWM_ON; mode = UPDOWN_COUNT; pin = 16'd5;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 59) == 0) onoff = (onoff == PWM_ON) ? PWM_OFF : PWM_ON;
      if ($urandom_range(0, 39) == 0) mode = count_mode_t'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0)
        pin = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 300)) : CW'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) presc = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
